// File: rtl/mux_nx1_reg_pkg.sv
// ---------------------------------------------------------------------------
// mux_nx1_reg_pkg
// Shared definitions for the registered N:1 multiplexer.
//   MODE_MANUAL / MODE_SCAN : encodings of the 1-bit mode input
//   sel_to_chan()           : maps a select value to the true channel index,
//                             applying the optional reversed (legacy) mapping
//                             and folding out-of-range results onto channel 0
// ---------------------------------------------------------------------------
package mux_nx1_reg_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Returns the channel addressed by 'sel'. With 'reversed' non-zero the
    // legacy mapping k -> n-1-k applies. Any result outside 0..n-1 selects
    // channel 0 so a bad select can never address a non-existent input.
    function automatic int sel_to_chan(input int sel, input int reversed, input int n);
        int c;
        if (reversed != 0) begin
            c = n - 1 - sel;
        end else begin
            c = sel;
        end
        if ((c < 0) || (c >= n)) begin
            c = 0;
        end else begin
            c = c;
        end
        return c;
    endfunction

endpackage

// File: rtl/mux_scan_ptr.sv
// ---------------------------------------------------------------------------
// mux_scan_ptr
// Round-robin channel pointer with a per-channel dwell counter.
//   clk, rst : clock and synchronous active-high reset
//   en       : scanning enabled; when low pointer and counter freeze
//   adv_req  : request an early advance (a word was taken from ptr)
//   ptr      : current channel, always in 0..N-1
// The pointer advances once when the dwell time expires or when adv_req is
// seen; both in the same cycle still give a single step.
// ---------------------------------------------------------------------------
module mux_scan_ptr
    import mux_nx1_reg_pkg::*;
#(
    parameter int N     = 4,
    parameter int SELW  = 2,
    parameter int DWELL = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            adv_req,
    output logic [SELW-1:0] ptr
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [CW-1:0]   cnt_r;
    logic [SELW-1:0] ptr_r;
    logic            last_s;
    logic            adv_s;

    assign last_s = (cnt_r == CW'(DWELL - 1));
    assign ptr    = ptr_r;

    // Decide whether the pointer steps this cycle (expiry OR early advance).
    always_comb begin
        adv_s = 1'b0;
        if (en && (last_s || adv_req)) begin
            adv_s = 1'b1;
        end else begin
            adv_s = 1'b0;
        end
    end

    // Dwell counter and pointer state; pointer wraps N-1 -> 0 explicitly.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= {SELW{1'b0}};
            cnt_r <= {CW{1'b0}};
        end else if (adv_s) begin
            cnt_r <= {CW{1'b0}};
            ptr_r <= (ptr_r == SELW'(N - 1)) ? {SELW{1'b0}} : ptr_r + SELW'(1);
        end else if (en) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/mux_nx1_reg.sv
// ---------------------------------------------------------------------------
// mux_nx1_reg
// N-channel, W-bit multiplexer with a registered valid/ready output stage.
//   clk, rst  : clock and synchronous active-high reset
//   mode      : MODE_MANUAL (external select) or MODE_SCAN (round robin)
//   select    : channel select, MANUAL mode only
//   ch_data   : flattened inputs, channel i at [i*W +: W]
//   ch_valid  : per-channel valid
//   ch_ready  : per-channel accept, one-hot or zero
//   data_out  : registered selected word
//   out_chan  : true channel number of the word in data_out
//   out_valid : data_out/out_chan hold a valid word
//   out_ready : downstream accept
// ---------------------------------------------------------------------------
module mux_nx1_reg
    import mux_nx1_reg_pkg::*;
#(
    parameter int N            = 4,
    parameter int W            = 8,
    parameter int SELW         = 2,
    parameter int SEL_REVERSED = 1,
    parameter int DWELL        = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode,
    input  logic [SELW-1:0] select,
    input  logic [N*W-1:0]  ch_data,
    input  logic [N-1:0]    ch_valid,
    output logic [N-1:0]    ch_ready,
    output logic [W-1:0]    data_out,
    output logic [SELW-1:0] out_chan,
    output logic            out_valid,
    input  logic            out_ready
);

    logic [SELW-1:0] ptr_s;
    logic [SELW-1:0] chan_s;
    logic [W-1:0]    sel_data_s;
    logic            sel_valid_s;
    logic            take_s;
    logic            load_s;
    logic [W-1:0]    data_r;
    logic [SELW-1:0] chan_r;
    logic            valid_r;

    // The output register can take a word when empty or being drained.
    assign take_s    = !valid_r || out_ready;
    assign load_s    = sel_valid_s && take_s;
    assign data_out  = data_r;
    assign out_chan  = chan_r;
    assign out_valid = valid_r;

    mux_scan_ptr #(
        .N     (N),
        .SELW  (SELW),
        .DWELL (DWELL)
    ) u_scan_ptr (
        .clk     (clk),
        .rst     (rst),
        .en      (mode == MODE_SCAN),
        .adv_req (load_s),
        .ptr     (ptr_s)
    );

    // Active channel: decoded select in MANUAL, scan pointer in SCAN.
    always_comb begin
        chan_s = {SELW{1'b0}};
        case (mode)
            MODE_MANUAL: chan_s = SELW'(sel_to_chan(int'(select), SEL_REVERSED, N));
            MODE_SCAN:   chan_s = ptr_s;
            default:     chan_s = {SELW{1'b0}};
        endcase
    end

    // Data/valid mux and one-hot ready; compare-based so chan_s never
    // needs to index past N-1 even when 2**SELW > N.
    always_comb begin
        sel_data_s  = {W{1'b0}};
        sel_valid_s = 1'b0;
        ch_ready    = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            sel_data_s  = (chan_s == SELW'(i)) ? ch_data[i*W +: W] : sel_data_s;
            sel_valid_s = (chan_s == SELW'(i)) ? ch_valid[i]       : sel_valid_s;
            ch_ready[i] = (chan_s == SELW'(i)) && take_s && !rst;
        end
    end

    // Output holding register; a load while draining replaces the word.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r  <= {W{1'b0}};
            chan_r  <= {SELW{1'b0}};
            valid_r <= 1'b0;
        end else if (load_s) begin
            data_r  <= sel_data_s;
            chan_r  <= chan_s;
            valid_r <= 1'b1;
        end else if (valid_r && out_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

endmodule

// File: tb/tb_mux_nx1_reg.sv
// ---------------------------------------------------------------------------
// tb_mux_nx1_reg
// Self-checking bench for mux_nx1_reg (N=4, W=8, reversed select, DWELL=3).
// A behavioural model tracks the output word, the scan channel and the time
// spent on it; directed scenarios also check fixed expected values.
// ---------------------------------------------------------------------------
module tb_mux_nx1_reg;
    import mux_nx1_reg_pkg::*;

    localparam int N       = 4;
    localparam int W       = 8;
    localparam int SELW    = 2;
    localparam int SEL_REV = 1;
    localparam int DWELL   = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            mode;
    logic [SELW-1:0] select;
    logic [N*W-1:0]  ch_data;
    logic [N-1:0]    ch_valid;
    logic [N-1:0]    ch_ready;
    logic [W-1:0]    data_out;
    logic [SELW-1:0] out_chan;
    logic            out_valid;
    logic            out_ready;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    int m_valid = 0;
    int m_data  = 0;
    int m_chan  = 0;
    int m_ptr   = 0;
    int m_spent = 0;   // cycles already spent on the current scan channel

    always #5 clk = ~clk;

    mux_nx1_reg #(
        .N(N), .W(W), .SELW(SELW), .SEL_REVERSED(SEL_REV), .DWELL(DWELL)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .select(select),
        .ch_data(ch_data), .ch_valid(ch_valid), .ch_ready(ch_ready),
        .data_out(data_out), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    function automatic int act_chan();
        if (mode == MODE_SCAN) return m_ptr;
        return sel_to_chan(int'(select), SEL_REV, N);
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        r = {N{1'b0}};
        if (rst || (m_valid != 0 && !out_ready)) return r;
        r[act_chan()] = 1'b1;
        return r;
    endfunction

    task automatic model_tick();
        int  c;
        bit  ld;
        c  = act_chan();
        ld = ch_valid[c] && (m_valid == 0 || out_ready);
        if (rst) begin
            m_valid = 0; m_data = 0; m_chan = 0; m_ptr = 0; m_spent = 0;
        end else begin
            if (ld) begin
                m_data  = int'(ch_data[c*W +: W]);
                m_chan  = c;
                m_valid = 1;
            end else if (m_valid != 0 && out_ready) begin
                m_valid = 0;
            end
            if (mode == MODE_SCAN) begin
                m_spent = m_spent + 1;
                if (m_spent >= DWELL || ld) begin
                    m_spent = 0;
                    m_ptr   = (m_ptr + 1) % N;
                end
            end
        end
    endtask

    // one clock: model follows the edge, return on the falling edge
    task automatic tick();
        @(posedge clk);
        model_tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = MODE_MANUAL; select = 2'b11; out_ready = 1'b1;
        ch_valid = 4'hF; ch_data = 32'h44332211;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if (ch_ready !== 4'b0000) begin
                bad++; $display("FAIL reset_ready got=%b want=0000", ch_ready);
            end
            tick();
            total++;
            if (out_valid !== 1'b0 || data_out !== 8'h00 || out_chan !== 2'd0) begin
                bad++; $display("FAIL reset_out got v=%b d=%h c=%0d want v=0 d=00 c=0",
                                out_valid, data_out, out_chan);
            end
        end
        rst = 1'b0;
        #1;
        total++;
        if (ch_ready !== 4'b0001) begin
            bad++; $display("FAIL reset_first_ready got=%b want=0001", ch_ready);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || data_out !== 8'h11 || out_chan !== 2'd0) begin
            bad++; $display("FAIL reset_first_load got v=%b d=%h c=%0d want v=1 d=11 c=0",
                            out_valid, data_out, out_chan);
        end
    endtask

    task automatic test_legacy();
        logic [W-1:0] want;
        mode = MODE_MANUAL; out_ready = 1'b1; ch_valid = 4'hF;
        ch_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int i = 0; i < 4; i++) begin
            select = SELW'(3 - i);
            #1;
            total++;
            if (ch_ready !== (4'b0001 << i)) begin
                bad++; $display("FAIL legacy_ready sel=%b got=%b want=%b", select, ch_ready, 4'b0001 << i);
            end
            tick();
            want = 8'hA0 + W'(i);
            total++;
            if (out_valid !== 1'b1 || data_out !== want || out_chan !== SELW'(i)) begin
                bad++; $display("FAIL legacy_out got d=%h c=%0d want d=%h c=%0d",
                                data_out, out_chan, want, i);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [N*W-1:0] nd;
        mode = MODE_MANUAL; select = 2'b00; out_ready = 1'b1; ch_valid = 4'hF;
        ch_data = {8'h5C, 8'h11, 8'h22, 8'h33};
        #1; tick();                              // loads 8'h5C from ch3
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ch_data = {$urandom};
            #1;
            total++;
            if (ch_ready !== 4'b0000) begin
                bad++; $display("FAIL stall_ready got=%b want=0000", ch_ready);
            end
            tick();
            total++;
            if (out_valid !== 1'b1 || data_out !== 8'h5C || out_chan !== 2'd3) begin
                bad++; $display("FAIL stall_hold got v=%b d=%h c=%0d want v=1 d=5c c=3",
                                out_valid, data_out, out_chan);
            end
        end
        nd = {8'hE7, 8'h01, 8'h02, 8'h03};
        ch_data = nd; out_ready = 1'b1;
        #1;
        total++;
        if (ch_ready !== 4'b1000) begin
            bad++; $display("FAIL release_ready got=%b want=1000", ch_ready);
        end
        tick();
        out_ready = 1'b0; ch_data = {$urandom};
        total++;
        if (out_valid !== 1'b1 || data_out !== 8'hE7) begin
            bad++; $display("FAIL release_load got v=%b d=%h want v=1 d=e7", out_valid, data_out);
        end
        #1; tick();
        total++;
        if (out_valid !== 1'b1 || data_out !== 8'hE7) begin
            bad++; $display("FAIL release_hold got v=%b d=%h want v=1 d=e7", out_valid, data_out);
        end
    endtask

    task automatic test_scan_wrap();
        rst = 1'b1; mode = MODE_MANUAL; ch_valid = 4'h0; out_ready = 1'b1;
        #1; tick();
        rst = 1'b0; mode = MODE_SCAN;
        for (int i = 0; i < 13; i++) begin
            #1;
            total++;
            if (ch_ready !== (4'b0001 << ((i / DWELL) % N))) begin
                bad++; $display("FAIL scan_wrap step=%0d got=%b want=%b", i, ch_ready,
                                4'b0001 << ((i / DWELL) % N));
            end
            tick();
            total++;
            if (out_valid !== 1'b0) begin
                bad++; $display("FAIL scan_wrap_valid step=%0d got=%b want=0", i, out_valid);
            end
        end
    endtask

    task automatic test_scan_early();
        rst = 1'b1; mode = MODE_MANUAL;
        #1; tick();
        rst = 1'b0; mode = MODE_SCAN; ch_valid = 4'hF; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ch_data = {$urandom};
            #1;
            total++;
            if (ch_ready !== (4'b0001 << (i % N))) begin
                bad++; $display("FAIL early_ready step=%0d got=%b want=%b", i, ch_ready, 4'b0001 << (i % N));
            end
            tick();
            total++;
            if (out_valid !== 1'b1 || out_chan !== SELW'(i % N) || data_out !== W'(m_data)) begin
                bad++; $display("FAIL early_load step=%0d got c=%0d d=%h want c=%0d d=%h",
                                i, out_chan, data_out, i % N, m_data);
            end
        end
        // pointer is at 1; let the dwell run to expiry, then load on that cycle
        ch_valid = 4'h0;
        #1; tick();
        #1; tick();
        ch_valid = 4'hF; ch_data = {$urandom};
        #1; tick();
        total++;
        if (out_chan !== 2'd1 || out_valid !== 1'b1) begin
            bad++; $display("FAIL coincide_load got c=%0d v=%b want c=1 v=1", out_chan, out_valid);
        end
        ch_valid = 4'h0;
        #1;
        total++;
        if (ch_ready !== 4'b0100) begin
            bad++; $display("FAIL coincide_single_adv got=%b want=0100", ch_ready);
        end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        mode = MODE_SCAN; ch_valid = 4'hF; out_ready = 1'b1; ch_data = {$urandom};
        #1; tick();                              // word loaded
        out_ready = 1'b0; ch_valid = 4'h0;
        #1; tick();
        #1; tick();
        rst = 1'b1;
        #1;
        total++;
        if (ch_ready !== 4'b0000) begin
            bad++; $display("FAIL midstall_ready got=%b want=0000", ch_ready);
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || data_out !== 8'h00) begin
            bad++; $display("FAIL midstall_clear got v=%b d=%h want v=0 d=00", out_valid, data_out);
        end
        rst = 1'b0; out_ready = 1'b1;
        #1;
        total++;
        if (ch_ready !== 4'b0001) begin
            bad++; $display("FAIL midstall_ptr got=%b want=0001", ch_ready);
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL midstall_lost got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 49) == 0);
            mode      = ($urandom_range(0, 3) != 0) ? MODE_SCAN : MODE_MANUAL;
            select    = SELW'($urandom);
            ch_valid  = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            ch_data   = {$urandom};
            #1;
            total++;
            if (ch_ready !== exp_ready()) begin
                bad++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", i, ch_ready, exp_ready());
            end
            tick();
            total++;
            if (out_valid !== m_valid[0] || data_out !== W'(m_data) || out_chan !== SELW'(m_chan)) begin
                bad++; $display("FAIL rand_out cyc=%0d got v=%b d=%h c=%0d want v=%0d d=%h c=%0d",
                                i, out_valid, data_out, out_chan, m_valid, m_data, m_chan);
            end
        end
    endtask

    initial begin
        test_reset();
        test_legacy();
        test_backpressure();
        test_scan_wrap();
        test_scan_early();
        test_reset_mid_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
